// File: rtl/ol_walker.sv
// Object-list walker: fetches OL words from VRAM, decodes strips/arrays/links, dispatches primitives to the ISP parser.
// Latency: start->ol_vram_rd 2 cycles; ol_vram_valid->render_poly 2 cycles; poly_drawn->next ol_vram_rd 2 cycles.
// Backpressure: one outstanding VRAM read held until ol_vram_valid; each dispatch stalls until poly_drawn.
//
// Ports:
//   clock, reset_n (synchronous, active low)
//   start, list_ptr, param_base          : walk request from the tile/region sequencer
//   ol_vram_rd/addr/din/valid            : single-outstanding OL word read port
//   opb_word, poly_addr, render_poly,
//   poly_drawn                           : dispatch handshake with the ISP parameter parser
//   busy, list_done, list_error          : walk status back to the sequencer
//   stat_strips/arrays/links             : walk statistics, present only when OL_WALKER_STATS_EN
//                                          is defined, otherwise tied to 0
module ol_walker #(
  parameter int MAX_ENTRIES = 4096,
  parameter int ADDR_W      = 24
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       list_ptr,
  input  logic [ADDR_W-1:0] param_base,
  output logic              ol_vram_rd,
  output logic [ADDR_W-1:0] ol_vram_addr,
  input  logic [31:0]       ol_vram_din,
  input  logic              ol_vram_valid,
  output logic [31:0]       opb_word,
  output logic [ADDR_W-1:0] poly_addr,
  output logic              render_poly,
  input  logic              poly_drawn,
  output logic              busy,
  output logic              list_done,
  output logic              list_error,
  output logic [15:0]       stat_strips,
  output logic [15:0]       stat_arrays,
  output logic [15:0]       stat_links
);

  localparam int CNT_W = $clog2(MAX_ENTRIES + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_DATA, DECODE, DISPATCH, WAIT_DRAWN, DONE, ERR
  } state_t;

  state_t            state_q, state_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       opb_word_q, opb_word_d;
  logic [ADDR_W-1:0] poly_addr_q, poly_addr_d;

  // Bits of the list pointer / OL word that carry no meaning for the walker.
  logic unused_bits;
  assign unused_bits = ^{list_ptr[30:24], list_ptr[1:0], word_q[24]};

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    opb_word_d  = opb_word_q;
    poly_addr_d = poly_addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (list_ptr[31]) begin
            state_d = DONE;
          end else begin
            addr_d  = {list_ptr[ADDR_W-1:2], 2'b00};
            cnt_d   = '0;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (cnt_q == CNT_W'(MAX_ENTRIES)) begin
          state_d = ERR;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          rd_d    = 1'b1;
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (ol_vram_valid) begin
          word_d  = ol_vram_din;
          rd_d    = 1'b0;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // Operands are loaded here so they are already valid while render_poly is high.
        opb_word_d  = word_q;
        poly_addr_d = param_base + ADDR_W'({word_q[20:0], 2'b00});
        if (!word_q[31]) begin
          if (word_q[30:25] == 6'd0) begin
            // Strip with an empty mask: nothing to draw, skip to the next word.
            opb_word_d  = opb_word_q;
            poly_addr_d = poly_addr_q;
            addr_d      = addr_q + ADDR_W'(4);
            state_d     = FETCH;
          end else begin
            state_d = DISPATCH;
          end
        end else if (!word_q[30]) begin
          state_d = DISPATCH;
        end else begin
          opb_word_d  = opb_word_q;
          poly_addr_d = poly_addr_q;
          if (!word_q[29]) begin
            state_d = ERR;
          end else if (word_q[28]) begin
            state_d = DONE;
          end else begin
            addr_d  = {word_q[ADDR_W-1:2], 2'b00};
            state_d = FETCH;
          end
        end
      end
      DISPATCH: state_d = WAIT_DRAWN;
      WAIT_DRAWN: begin
        if (poly_drawn) begin
          addr_d  = addr_q + ADDR_W'(4);
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      opb_word_q  <= '0;
      poly_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      opb_word_q  <= opb_word_d;
      poly_addr_q <= poly_addr_d;
    end
  end

  assign ol_vram_rd   = rd_q;
  assign ol_vram_addr = addr_q;
  assign opb_word     = opb_word_q;
  assign poly_addr    = poly_addr_q;
  assign render_poly  = (state_q == DISPATCH);
  assign list_done    = (state_q == DONE);
  assign list_error   = (state_q == ERR);
  assign busy         = (state_q != IDLE);

`ifdef OL_WALKER_STATS_EN
  logic [15:0] stat_strips_q, stat_strips_d;
  logic [15:0] stat_arrays_q, stat_arrays_d;
  logic [15:0] stat_links_q, stat_links_d;

  always_comb begin
    stat_strips_d = stat_strips_q;
    stat_arrays_d = stat_arrays_q;
    stat_links_d  = stat_links_q;
    if (state_q == IDLE) begin
      if (start) begin
        stat_strips_d = '0;
        stat_arrays_d = '0;
        stat_links_d  = '0;
      end
    end else if (state_q == DISPATCH) begin
      // opb_word_q holds the word being dispatched; bit31 separates strips from arrays.
      if (!opb_word_q[31]) begin
        if (stat_strips_q != 16'hFFFF) stat_strips_d = stat_strips_q + 16'd1;
      end else begin
        if (stat_arrays_q != 16'hFFFF) stat_arrays_d = stat_arrays_q + 16'd1;
      end
    end else if (state_q == DECODE && word_q[31:29] == 3'b111 && !word_q[28]) begin
      if (stat_links_q != 16'hFFFF) stat_links_d = stat_links_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stat_strips_q <= '0;
      stat_arrays_q <= '0;
      stat_links_q  <= '0;
    end else begin
      stat_strips_q <= stat_strips_d;
      stat_arrays_q <= stat_arrays_d;
      stat_links_q  <= stat_links_d;
    end
  end

  assign stat_strips = stat_strips_q;
  assign stat_arrays = stat_arrays_q;
  assign stat_links  = stat_links_q;
`else
  assign stat_strips = 16'd0;
  assign stat_arrays = 16'd0;
  assign stat_links  = 16'd0;
`endif

endmodule

// File: tb/tb_ol_walker.sv
// Directed bench for ol_walker: empty list, strip dispatch, array + link follow with param wrap,
// zero-mask strip with address wrap, reserved word, runaway guard, and reset during WAIT_DRAWN.
module tb_ol_walker;

`ifdef OL_WALKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] list_ptr;
  logic [23:0] param_base;
  logic        ol_vram_rd;
  logic [23:0] ol_vram_addr;
  logic [31:0] ol_vram_din;
  logic        ol_vram_valid;
  logic [31:0] opb_word;
  logic [23:0] poly_addr;
  logic        render_poly;
  logic        poly_drawn;
  logic        busy;
  logic        list_done;
  logic        list_error;
  logic [15:0] stat_strips;
  logic [15:0] stat_arrays;
  logic [15:0] stat_links;

  int vectors = 0;
  int miscompares = 0;

  ol_walker #(.MAX_ENTRIES(4), .ADDR_W(24)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .list_ptr(list_ptr),
    .param_base(param_base), .ol_vram_rd(ol_vram_rd), .ol_vram_addr(ol_vram_addr),
    .ol_vram_din(ol_vram_din), .ol_vram_valid(ol_vram_valid), .opb_word(opb_word),
    .poly_addr(poly_addr), .render_poly(render_poly), .poly_drawn(poly_drawn),
    .busy(busy), .list_done(list_done), .list_error(list_error),
    .stat_strips(stat_strips), .stat_arrays(stat_arrays), .stat_links(stat_links)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_walk(input logic [31:0] p);
    start = 1'b1;
    list_ptr = p;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_rd();
    int n = 0;
    while (ol_vram_rd !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("rd_req", ol_vram_rd, 1'b1);
  endtask

  // Answer one OL read after lat extra cycles; returns at the DECODE-state negedge.
  task automatic serve(input logic [23:0] a, input logic [31:0] d, input int lat);
    wait_rd();
    chk("rd_addr", ol_vram_addr, a);
    for (int i = 0; i < lat; i++) begin
      @(negedge clock);
      vectors++;
      if (ol_vram_rd !== 1'b1) begin
        miscompares++;
        $error("FAIL rd_hold: observed %0h expected 1", ol_vram_rd);
      end
      vectors++;
      if (ol_vram_addr !== a) begin
        miscompares++;
        $error("FAIL addr_hold: observed %0h expected %0h", ol_vram_addr, a);
      end
    end
    ol_vram_din = d;
    ol_vram_valid = 1'b1;
    @(negedge clock);
    ol_vram_valid = 1'b0;
    ol_vram_din = 32'h0;
    chk("rd_drop", ol_vram_rd, 1'b0);
  endtask

  task automatic dispatch_chk(input logic [31:0] w, input logic [23:0] p);
    @(negedge clock);
    chk("render_hi", render_poly, 1'b1);
    chk("opb_word", opb_word, w);
    chk("poly_addr", poly_addr, p);
    @(negedge clock);
    chk("render_lo", render_poly, 1'b0);
    chk("opb_hold", opb_word, w);
    chk("poly_hold", poly_addr, p);
  endtask

  task automatic drawn_pulse();
    poly_drawn = 1'b1;
    @(negedge clock);
    poly_drawn = 1'b0;
    chk("rd_after_drawn_1", ol_vram_rd, 1'b0);
    @(negedge clock);
    chk("rd_after_drawn_2", ol_vram_rd, 1'b1);
  endtask

  task automatic expect_done();
    @(negedge clock);
    chk("list_done_hi", list_done, 1'b1);
    chk("list_error_lo", list_error, 1'b0);
    @(negedge clock);
    chk("list_done_lo", list_done, 1'b0);
    chk("busy_idle", busy, 1'b0);
  endtask

  task automatic stats_chk(input logic [15:0] s, input logic [15:0] a, input logic [15:0] l);
    chk("stat_strips", stat_strips, (STATS ? s : 16'd0));
    chk("stat_arrays", stat_arrays, (STATS ? a : 16'd0));
    chk("stat_links", stat_links, (STATS ? l : 16'd0));
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    list_ptr = 32'h0;
    param_base = 24'h100000;
    ol_vram_din = 32'h0;
    ol_vram_valid = 1'b0;
    poly_drawn = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_rd", ol_vram_rd, 1'b0);
    chk("rst_addr", ol_vram_addr, 24'h0);
    chk("rst_opb", opb_word, 32'h0);
    chk("rst_poly", poly_addr, 24'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", list_done, 1'b0);
    stats_chk(16'd0, 16'd0, 16'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Empty list: done pulse, no VRAM read.
    start_walk(32'h8000_0000);
    chk("empty_done", list_done, 1'b1);
    chk("empty_rd", ol_vram_rd, 1'b0);
    chk("empty_busy", busy, 1'b1);
    @(negedge clock);
    chk("empty_done_lo", list_done, 1'b0);
    chk("empty_rd_lo", ol_vram_rd, 1'b0);
    chk("empty_busy_lo", busy, 1'b0);

    // Strip then EOL link; VRAM stalls 10 cycles; a start while busy is ignored.
    start_walk(32'h0000_1000);
    chk("fetch_rd_lo", ol_vram_rd, 1'b0);
    serve(24'h001000, 32'h0200_0010, 10);
    dispatch_chk(32'h0200_0010, 24'h100040);
    start = 1'b1;
    list_ptr = 32'h8000_0000;
    @(negedge clock);
    start = 1'b0;
    chk("busy_start_ignored", busy, 1'b1);
    chk("done_start_ignored", list_done, 1'b0);
    repeat (3) @(negedge clock);
    chk("wait_drawn_render", render_poly, 1'b0);
    chk("wait_drawn_rd", ol_vram_rd, 1'b0);
    drawn_pulse();
    serve(24'h001004, 32'hF000_0000, 0);
    expect_done();
    stats_chk(16'd1, 16'd0, 16'd0);

    // poly_drawn while idle does nothing.
    poly_drawn = 1'b1;
    @(negedge clock);
    poly_drawn = 1'b0;
    @(negedge clock);
    chk("idle_drawn_busy", busy, 1'b0);
    chk("idle_drawn_rd", ol_vram_rd, 1'b0);

    // Tri array, link to 0x3000, EOL; param_base + 0x80 wraps past 2^24.
    param_base = 24'hFFFFC0;
    start_walk(32'h0000_2000);
    serve(24'h002000, 32'h8000_0020, 2);
    dispatch_chk(32'h8000_0020, 24'h000040);
    drawn_pulse();
    serve(24'h002004, 32'hE000_3000, 0);
    serve(24'h003000, 32'hF000_0000, 1);
    expect_done();
    stats_chk(16'd0, 16'd1, 16'd1);

    // Zero-mask strip at the top of the address space: no dispatch, next fetch wraps to 0.
    start_walk(32'h00FF_FFFC);
    serve(24'hFFFFFC, 32'h0000_0004, 0);
    @(negedge clock);
    chk("skip_render", render_poly, 1'b0);
    serve(24'h000000, 32'hF000_0000, 0);
    expect_done();
    stats_chk(16'd0, 16'd0, 16'd0);

    // Reserved word aborts the list.
    start_walk(32'h0000_5000);
    serve(24'h005000, 32'hC000_0000, 0);
    @(negedge clock);
    chk("resv_error", list_error, 1'b1);
    chk("resv_done", list_done, 1'b0);
    @(negedge clock);
    chk("resv_error_lo", list_error, 1'b0);
    chk("resv_busy", busy, 1'b0);

    // Runaway guard: four fetches allowed, the fifth attempt errors without a read.
    start_walk(32'h0000_6000);
    for (int k = 0; k < 4; k++) begin
      serve(24'h006000 + 24'(k * 4), 32'h0000_0000, 0);
    end
    @(negedge clock);
    chk("guard_fetch_err", list_error, 1'b0);
    @(negedge clock);
    chk("guard_error", list_error, 1'b1);
    chk("guard_rd", ol_vram_rd, 1'b0);
    @(negedge clock);
    chk("guard_busy", busy, 1'b0);

    // Reset during WAIT_DRAWN abandons the walk silently.
    param_base = 24'h100000;
    start_walk(32'h0000_7000);
    serve(24'h007000, 32'h0200_0010, 0);
    dispatch_chk(32'h0200_0010, 24'h100040);
    reset_n = 1'b0;
    @(negedge clock);
    chk("mid_rst_rd", ol_vram_rd, 1'b0);
    chk("mid_rst_addr", ol_vram_addr, 24'h0);
    chk("mid_rst_opb", opb_word, 32'h0);
    chk("mid_rst_poly", poly_addr, 24'h0);
    chk("mid_rst_render", render_poly, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", list_done, 1'b0);
    chk("mid_rst_error", list_error, 1'b0);
    stats_chk(16'd0, 16'd0, 16'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_done", list_done, 1'b0);
    chk("post_rst_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
